// File: rtl/option_price_calc.sv
// Black-Scholes final stage: discounts the strike, weights by N(d1)/N(d2) and
// produces a clamped call/put price in Q16.16, four register stages deep.
module option_price_calc #(
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] rate,
   input  logic signed [WIDTH-1:0] timetm,
   input  logic signed [WIDTH-1:0] spot,
   input  logic signed [WIDTH-1:0] strike,
   input  logic signed [WIDTH-1:0] Nd1,
   input  logic signed [WIDTH-1:0] Nd2,
   input  logic                    otype,
   output logic signed [WIDTH-1:0] OptionPrice
);

   // log2(e) in Q1.30 and ln(2) in Q0.16
   localparam logic [30:0] LOG2E = 31'd1549082005;
   localparam logic [27:0] LN2   = 28'd45426;

   function automatic logic [16:0] clampProb(input logic signed [31:0] v);
      if (v < 0)               return '0;
      else if (v > 32'sd65536) return 17'd65536;
      else                     return v[16:0];
   endfunction

   // 2^(-k/16) in Q0.16 for the top four fraction bits of the exponent
   function automatic logic [16:0] expLut(input logic [3:0] idx);
      case (idx)
         4'd0:  return 17'd65536;  4'd1:  return 17'd62757;
         4'd2:  return 17'd60097;  4'd3:  return 17'd57549;
         4'd4:  return 17'd55109;  4'd5:  return 17'd52773;
         4'd6:  return 17'd50535;  4'd7:  return 17'd48393;
         4'd8:  return 17'd46341;  4'd9:  return 17'd44376;
         4'd10: return 17'd42495;  4'd11: return 17'd40693;
         4'd12: return 17'd38968;  4'd13: return 17'd37316;
         4'd14: return 17'd35734;  default: return 17'd34219;
      endcase
   endfunction

   logic [30:0] spot1_q, spot1_d, strike1_q, strike1_d, spot2_q, strike2_q;
   logic [16:0] nd1_1_q, nd1_1_d, nd2_1_q, nd2_1_d, nd1_2_q, nd2_2_q, nd2_3_q;
   logic        otype1_q, otype2_q, otype3_q;
   logic [20:0] x1_q, x1_d;
   logic [16:0] d2_q, d2_d;
   logic [30:0] kd3_q, kd3_d, spotTerm3_q, spotTerm3_d;
   logic [31:0] price_q, price_d;

   logic signed [63:0] rtProd, xFull;
   logic [51:0] yProd;
   logic [20:0] y;
   logic [11:0] a;
   logic [23:0] aSq;
   logic [16:0] poly, dFrac, spotW, kW;
   logic [33:0] fracProd;
   logic [30:0] kTerm;
   logic signed [32:0] diff;

   // Stage 1: clamp operands and form x = r*T, saturated to [0, 16.0]
   always_comb begin
      rtProd    = 64'(rate) * 64'(timetm);
      xFull     = rtProd >>> 16;
      spot1_d   = spot[WIDTH-1]   ? '0 : spot[30:0];
      strike1_d = strike[WIDTH-1] ? '0 : strike[30:0];
      nd1_1_d   = clampProb(Nd1);
      nd2_1_d   = clampProb(Nd2);
      if (xFull <= 64'sd0)             x1_d = '0;
      else if (xFull >= 64'sd1048576)  x1_d = 21'h100000;
      else                             x1_d = xFull[20:0];
   end

   // Stage 2: D = 2^(-x*log2 e); integer part shifts, fraction is LUT times a
   // second-order series over the low twelve bits
   always_comb begin
      yProd    = 52'(x1_q) * 52'(LOG2E);
      y        = 21'(yProd >> 30);
      a        = 12'((28'(y[11:0]) * LN2) >> 16);
      aSq      = 24'(a) * 24'(a);
      poly     = 17'd65536 - 17'(a) + 17'(aSq >> 17);
      fracProd = 34'(expLut(y[15:12])) * 34'(poly);
      dFrac    = 17'(fracProd >> 16);
      d2_d     = x1_q[20] ? '0 : 17'(dFrac >> y[20:16]);
   end

   // Stage 3: discounted strike and the spot leg of the selected payoff
   always_comb begin
      spotW       = otype2_q ? (17'd65536 - nd1_2_q) : nd1_2_q;
      spotTerm3_d = 31'((48'(spot2_q) * 48'(spotW)) >> 16);
      kd3_d       = 31'((48'(strike2_q) * 48'(d2_q)) >> 16);
   end

   // Stage 4: strike leg, combine, clamp into the non-negative Q16.16 range
   always_comb begin
      kW    = otype3_q ? (17'd65536 - nd2_3_q) : nd2_3_q;
      kTerm = 31'((48'(kd3_q) * 48'(kW)) >> 16);
      if (otype3_q) diff = $signed({2'b00, kTerm}) - $signed({2'b00, spotTerm3_q});
      else          diff = $signed({2'b00, spotTerm3_q}) - $signed({2'b00, kTerm});
      if (diff < 0)                     price_d = '0;
      else if (diff > 33'sh07FFFFFFF)   price_d = 32'h7FFFFFFF;
      else                              price_d = diff[31:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spot1_q <= '0;  strike1_q <= '0;  nd1_1_q <= '0;  nd2_1_q <= '0;
         otype1_q <= 1'b0;  x1_q <= '0;
         spot2_q <= '0;  strike2_q <= '0;  nd1_2_q <= '0;  nd2_2_q <= '0;
         otype2_q <= 1'b0;  d2_q <= '0;
         kd3_q <= '0;  spotTerm3_q <= '0;  nd2_3_q <= '0;  otype3_q <= 1'b0;
         price_q <= '0;
      end else begin
         spot1_q <= spot1_d;  strike1_q <= strike1_d;
         nd1_1_q <= nd1_1_d;  nd2_1_q <= nd2_1_d;
         otype1_q <= otype;   x1_q <= x1_d;
         spot2_q <= spot1_q;  strike2_q <= strike1_q;
         nd1_2_q <= nd1_1_q;  nd2_2_q <= nd2_1_q;
         otype2_q <= otype1_q;  d2_q <= d2_d;
         kd3_q <= kd3_d;  spotTerm3_q <= spotTerm3_d;
         nd2_3_q <= nd2_2_q;  otype3_q <= otype2_q;
         price_q <= price_d;
      end
   end

   assign OptionPrice = price_q;

endmodule

// File: tb/tb_option_price_calc.sv
// Bench for option_price_calc: directed pricing cases plus random streams,
// scored against a real-valued Black-Scholes model.
module tb_option_price_calc;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [31:0] rate, timetm, spot, strike, Nd1, Nd2;
   logic               otype;
   logic signed [31:0] OptionPrice;

   int compared = 0;
   int mismatched = 0;

   longint expQ[$];
   longint tolQ[$];
   string  tagQ[$];
   longint popObs[$];
   string  popTag[$];

   always #5 clk = ~clk;

   option_price_calc #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .rate(rate), .timetm(timetm),
      .spot(spot), .strike(strike), .Nd1(Nd1), .Nd2(Nd2),
      .otype(otype), .OptionPrice(OptionPrice)
   );

   task automatic checkOutput(input string tag, input longint observed,
                              input longint expected, input longint tol);
      longint diff;
      compared++;
      diff = observed - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tolerance %0d)",
                  tag, observed, expected, tol);
      end
   endtask

   // Ideal price from the closed form using real arithmetic
   task automatic modelPrice(input int s, input int k, input int r, input int t,
                             input int n1, input int n2, input logic ot,
                             output longint expv, output longint tol);
      real    sr, kr, n1r, n2r, d, price;
      longint x;
      sr  = (s < 0) ? 0.0 : real'(s) / 65536.0;
      kr  = (k < 0) ? 0.0 : real'(k) / 65536.0;
      n1r = (n1 < 0) ? 0.0 : (n1 > 65536) ? 1.0 : real'(n1) / 65536.0;
      n2r = (n2 < 0) ? 0.0 : (n2 > 65536) ? 1.0 : real'(n2) / 65536.0;
      x = (longint'(r) * longint'(t)) >>> 16;
      if (x <= 0)            d = 1.0;
      else if (x >= 1048576) d = 0.0;
      else                   d = $exp(-real'(x) / 65536.0);
      if (ot) price = kr * d * (1.0 - n2r) - sr * (1.0 - n1r);
      else    price = sr * n1r - kr * d * n2r;
      price = price * 65536.0;
      if (price < 0.0)          price = 0.0;
      if (price > 2147483647.0) price = 2147483647.0;
      expv = longint'(price);
      tol  = 9 + longint'($ceil(8.0 * kr));
   endtask

   task automatic applyStimulus(input string tag, input int s, input int k,
                                input int r, input int t, input int n1,
                                input int n2, input logic ot,
                                input longint forceExp = -1);
      longint e, tl;
      spot = s; strike = k; rate = r; timetm = t;
      Nd1 = n1; Nd2 = n2; otype = ot;
      modelPrice(s, k, r, t, n1, n2, ot, e, tl);
      if (forceExp >= 0) begin
         e  = forceExp;
         tl = 0;
      end
      expQ.push_back(e); tolQ.push_back(tl); tagQ.push_back(tag);
      @(posedge clk); #1;
      if (expQ.size() == 4) begin
         popObs.push_back(longint'(OptionPrice));
         popTag.push_back(tagQ[0]);
         checkOutput(tagQ.pop_front(), longint'(OptionPrice),
                     expQ.pop_front(), tolQ.pop_front());
      end else begin
         checkOutput("fill", longint'(OptionPrice), 0, 0);
      end
   endtask

   task automatic randomStep();
      int s, k, r, t, n1, n2;
      s = int'($urandom_range(0, 19660800));
      if ($urandom_range(0, 9) == 0) s = -s;
      k = int'($urandom_range(0, 19660800));
      if ($urandom_range(0, 9) == 0) k = -k;
      r = int'($urandom_range(0, 26214)) - 3277;
      if ($urandom_range(0, 7) == 0) r = int'($urandom_range(65536, 262144));
      t  = int'($urandom_range(0, 655360));
      n1 = int'($urandom_range(0, 72000)) - 3000;
      n2 = int'($urandom_range(0, 72000)) - 3000;
      applyStimulus("rand", s, k, r, t, n1, n2, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      longint cVal, pVal;
      bit     cFound, pFound;
      real    parityExp;

      reset = 1'b0;
      spot = 0; strike = 0; rate = 0; timetm = 0; Nd1 = 0; Nd2 = 0; otype = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset", longint'(OptionPrice), 0, 0);
      @(negedge clk);
      reset = 1'b1;

      applyStimulus("refCall",  6553600, 6553600, 3277, 65536, 41735, 36675, 1'b0);
      applyStimulus("refPut",   6553600, 6553600, 3277, 65536, 41735, 36675, 1'b1);
      applyStimulus("zeroCall", 7864320, 6553600, 0, 65536, 65536, 65536, 1'b0, 1310720);
      applyStimulus("zeroPut",  7864320, 6553600, 0, 65536, 65536, 65536, 1'b1, 0);
      applyStimulus("clampNeg", 3276800, 6553600, 0, 65536, 0, 65536, 1'b0, 0);
      applyStimulus("clampNd1", 3276800, 6553600, 0, 65536, 70000, 65536, 1'b0, 0);
      applyStimulus("bigX",     6553600, 6553600, 131072, 655360, 41735, 36675, 1'b0);

      for (int i = 0; i < 200; i++) randomStep();

      // Keep the pipeline busy, then pull reset between edges
      applyStimulus("preRst", 6553600, 3276800, 3277, 65536, 60000, 50000, 1'b0);
      #2 reset = 1'b0;
      #1 checkOutput("asyncRst", longint'(OptionPrice), 0, 0);
      expQ.delete(); tolQ.delete(); tagQ.delete();
      @(posedge clk); #1;
      checkOutput("rstHold", longint'(OptionPrice), 0, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++)
         applyStimulus("postRst", 6553600, 6553600, 3277, 65536, 41735, 36675, 1'b0);

      for (int i = 0; i < 20; i++) randomStep();

      cVal = 0; pVal = 0; cFound = 1'b0; pFound = 1'b0;
      foreach (popTag[i]) begin
         if (!cFound && popTag[i] == "refCall") begin cVal = popObs[i]; cFound = 1'b1; end
         if (!pFound && popTag[i] == "refPut")  begin pVal = popObs[i]; pFound = 1'b1; end
      end
      parityExp = 6553600.0 - 6553600.0 * $exp(-3277.0 / 65536.0);
      checkOutput("parity", cVal - pVal, longint'(parityExp), 1618);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
